// File: rtl/unsigned_serial_subtractor.sv
// Multi-cycle unsigned subtractor: computes x - y as a ripple-borrow chain,
// digit bits per clock, under a start/busy/done handshake.
module unsigned_serial_subtractor #(
    parameter int size  = 8,
    parameter int digit = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [size-1:0] x,
    input  logic [size-1:0] y,
    output logic            busy,
    output logic            done,
    output logic [size-1:0] d,
    output logic            bout,
    output logic            zero
);

    localparam int steps = size / digit;
    localparam int cw    = (steps > 1) ? $clog2(steps) : 1;
    localparam logic [cw-1:0] last_count = cw'(steps - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [size-1:0] x_sh;
    logic [size-1:0] y_sh;
    logic [size-1:0] part;
    logic            borrow;
    logic [cw-1:0]   count;

    logic            accept;
    logic            final_step;
    logic [digit:0]  slice_diff;
    logic            borrow_next;
    logic [size-1:0] part_next;

    // NOTE: every combinational output gets a default before the case so no
    // path through the block leaves a signal unassigned (which infers a latch).
    always_comb begin
        accept     = start && (state != RUN);
        final_step = (state == RUN) && (count == last_count);
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (final_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The slice is computed with a leading 1 so a set MSB means "no borrow".
    always_comb begin
        slice_diff  = {1'b1, x_sh[digit-1:0]} - {1'b0, y_sh[digit-1:0]}
                      - {{digit{1'b0}}, borrow};
        borrow_next = ~slice_diff[digit];
        part_next   = part >> digit;
        part_next[size-1 -: digit] = slice_diff[digit-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the operand and partial registers are plain flops, not a memory,
    // so they take the asynchronous clear along with the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sh   <= '0;
            y_sh   <= '0;
            part   <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            x_sh   <= x;
            y_sh   <= y;
            part   <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else if (state == RUN) begin
            x_sh   <= x_sh >> digit;
            y_sh   <= y_sh >> digit;
            part   <= part_next;
            borrow <= borrow_next;
            count  <= count + 1'b1;
        end
    end

    // Results update only on the completion edge and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= final_step;
            if (final_step) begin
                d    <= part_next;
                bout <= borrow_next;
                zero <= (part_next == '0);
            end
        end
    end

endmodule
